// File: rtl/mux2_arbiter.sv
// Two-input arbiter feeding one output register; ties go to i0, or alternate with MUX2_ARBITER_RR_EN.
// Latency: 1 cycle from accept to out_valid. Backpressure: out_ready low while FULL stalls both inputs.
module mux2_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i0_valid,
  input  logic [31:0] i0_data,
  output logic        i0_ready,
  input  logic        i1_valid,
  input  logic [31:0] i1_data,
  output logic        i1_ready,
  output logic        out_valid,
  output logic [31:0] out,
  output logic        out_sel,
  input  logic        out_ready,
  output logic [15:0] cnt0,
  output logic [15:0] cnt1
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        load;
  logic        grant;
  logic        xfer;
  logic        last_sel;
  logic [31:0] gdata;

  always_comb begin
    load      = !rst && ((state == EMPTY) || out_ready);
    grant     = 1'b0;
    if (i0_valid && i1_valid) begin
`ifdef MUX2_ARBITER_RR_EN
      grant = ~last_sel;
`else
      // last_sel is still tracked but never decides a tie here.
      grant = 1'b0 & last_sel;
`endif
    end else if (i1_valid) begin
      grant = 1'b1;
    end
    xfer      = load && (i0_valid || i1_valid);
    i0_ready  = xfer && !grant;
    i1_ready  = xfer && grant;
    gdata     = grant ? i1_data : i0_data;
    state_nxt = state;
    if (xfer) begin
      state_nxt = FULL;
    end else if (load) begin
      state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out      <= 32'd0;
      out_sel  <= 1'b0;
      last_sel <= 1'b1;
      cnt0     <= 16'd0;
      cnt1     <= 16'd0;
    end else if (xfer) begin
      out      <= gdata;
      out_sel  <= grant;
      last_sel <= grant;
      if (grant) begin
        cnt1 <= cnt1 + 16'd1;
      end else begin
        cnt0 <= cnt0 + 16'd1;
      end
    end
  end

  assign out_valid = (state == FULL);

endmodule

// File: tb/tb_mux2_arbiter.sv
// Scoreboard bench for mux2_arbiter: driver predicts grants from arbitration rules, monitor checks the output register.
module tb_mux2_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i0_valid = 1'b0;
  logic [31:0] i0_data = 32'd0;
  logic        i0_ready;
  logic        i1_valid = 1'b0;
  logic [31:0] i1_data = 32'd0;
  logic        i1_ready;
  logic        out_valid;
  logic [31:0] out;
  logic        out_sel;
  logic        out_ready = 1'b0;
  logic [15:0] cnt0;
  logic [15:0] cnt1;

  mux2_arbiter dut (
    .clk(clk), .rst(rst),
    .i0_valid(i0_valid), .i0_data(i0_data), .i0_ready(i0_ready),
    .i1_valid(i1_valid), .i1_data(i1_data), .i1_ready(i1_ready),
    .out_valid(out_valid), .out(out), .out_sel(out_sel), .out_ready(out_ready),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

`ifdef MUX2_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [32:0] sb[$];
  bit          m_full = 1'b0;
  bit          m_last = 1'b1;
  logic [15:0] m_cnt0 = 16'd0;
  logic [15:0] m_cnt1 = 16'd0;
  bit          prev_rst = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: whatever the register shows must be the oldest word accepted and not yet consumed.
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected actual=%h expected=none at %0t", out, $time);
      end else begin
        chk("out_word", {31'd0, out_sel} ^ 32'd0, {31'd0, sb[0][32]});
        chk("out_data", out, sb[0][31:0]);
        if (out_ready && !rst) void'(sb.pop_front());
      end
    end
  end

  task automatic cyc(input logic r, input logic v0, input logic [31:0] d0,
                     input logic v1, input logic [31:0] d1, input logic ordy);
    bit can;
    bit pick;
    bit e0;
    bit e1;
    @(posedge clk);
    #1;
    if (prev_rst) begin
      sb.delete();
      m_full = 1'b0;
      m_last = 1'b1;
      m_cnt0 = 16'd0;
      m_cnt1 = 16'd0;
      chk("rst_out", out, 32'd0);
      chk("rst_sel", {31'd0, out_sel}, 32'd0);
    end
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_full});
    chk("cnt0", {16'd0, cnt0}, {16'd0, m_cnt0});
    chk("cnt1", {16'd0, cnt1}, {16'd0, m_cnt1});
    rst = r; i0_valid = v0; i0_data = d0; i1_valid = v1; i1_data = d1; out_ready = ordy;
    #1;
    can = !r && (!m_full || ordy);
    e0 = 1'b0;
    e1 = 1'b0;
    if (can && (v0 || v1)) begin
      if (v0 && v1) pick = RR ? !m_last : 1'b0;
      else          pick = v1;
      if (pick) begin e1 = 1'b1; m_cnt1 = m_cnt1 + 16'd1; sb.push_back({1'b1, d1}); end
      else      begin e0 = 1'b1; m_cnt0 = m_cnt0 + 16'd1; sb.push_back({1'b0, d0}); end
      m_last = pick;
      m_full = 1'b1;
    end else if (can) begin
      m_full = 1'b0;
    end
    chk("i0_ready", {31'd0, i0_ready}, {31'd0, e0});
    chk("i1_ready", {31'd0, i1_ready}, {31'd0, e1});
    prev_rst = r;
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);

    // Single i0 word straight through.
    cyc(0, 1, 32'hA5A5A5A5, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("first_out", out, 32'hA5A5A5A5);
    chk("first_cnt0", {16'd0, cnt0}, 32'd1);

    // Continuous tie from reset.
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 32'h11111111, 1, 32'h22222222, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("tie_cnt0", {16'd0, cnt0}, RR ? 32'd2 : 32'd4);
    chk("tie_cnt1", {16'd0, cnt1}, RR ? 32'd2 : 32'd0);

    // Stall while FULL, then release to i1.
    cyc(0, 1, 32'hCAFE0001, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 32'hBEEF0002, 0);
    cyc(0, 0, 0, 1, 32'hBEEF0002, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("stall_release", out, 32'hBEEF0002);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);

    // Reset while holding a stalled word, then a tie.
    cyc(0, 0, 0, 1, 32'h33333333, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h44444444, 1, 32'h55555555, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("post_rst_tie", {31'd0, out_sel}, 32'd0);
    cyc(0, 0, 0, 0, 0, 1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 63) == 0), $urandom_range(0, 1), $urandom,
          $urandom_range(0, 1), $urandom, ($urandom_range(0, 3) != 0));

    // Counter wrap on i0.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h77777777, 1);
    for (int i = 0; i < 65536; i++) cyc(0, 1, $urandom, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("wrap_cnt0", {16'd0, cnt0}, 32'd0);
    chk("wrap_cnt1", {16'd0, cnt1}, 32'd1);

    cyc(0, 0, 0, 0, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
